// File: rtl/omsp_watchdog_pkg.sv
// Shared constants for the watchdog timer: WDTCTL bit positions, the
// write password, the read signature and the expiry tap mask helper.
package omsp_watchdog_pkg;

  // WDTCTL bit positions
  localparam int WDTHOLD  = 7;
  localparam int WDTTMSEL = 4;
  localparam int WDTCNTCL = 3;
  localparam int WDTSSEL  = 2;
  localparam int WDTIS0   = 0;

  // Upper byte of WDTCTL: password on write, signature on read
  localparam logic [7:0] WDT_PASSWORD  = 8'h5A;
  localparam logic [7:0] WDT_SIGNATURE = 8'h69;

  // Storable WDTCTL bits. CNTCL is a strobe and bits 6:5 do not exist.
  localparam logic [7:0] WDTCTL_MASK_FULL  = 8'h97;
  // Without interval mode TMSEL is not storable either.
  localparam logic [7:0] WDTCTL_MASK_NOINT = 8'h87;

  // Bits below the expiry tap selected by IS. Expiry happens on a tick
  // while all of these bits are 1.
  function automatic logic [15:0] wdt_tap_mask(input logic [1:0] wdtis);
    logic [15:0] mask;
    case (wdtis)
      2'b00:   mask = 16'h7FFF;  // tap bit 15, /32768
      2'b01:   mask = 16'h1FFF;  // tap bit 13, /8192
      2'b10:   mask = 16'h01FF;  // tap bit 9,  /512
      default: mask = 16'h003F;  // tap bit 6,  /64
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/omsp_wdt_counter.sv
// 16-bit watchdog counter with tap mux and expiry compare. Counter clear
// has priority over expiry: a clear in the expiry cycle suppresses it.
module omsp_wdt_counter
  import omsp_watchdog_pkg::*;
(
  input  logic       mclk,
  input  logic       puc_rst,
  input  logic       tick,
  input  logic       cnt_clr,
  input  logic [1:0] wdtis,
  output logic       expire
);

  logic [15:0] wdtcnt;
  logic [15:0] tap_mask;

  assign tap_mask = wdt_tap_mask(wdtis);

  // Masked compare so a change of IS mid-count never skips a wrap
  assign expire = tick & ~cnt_clr & ((wdtcnt & tap_mask) == tap_mask);

  // Counter: clear, wrap to zero on expiry, or count on tick
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      wdtcnt <= 16'h0000;
    end else if (cnt_clr || expire) begin
      wdtcnt <= 16'h0000;
    end else if (tick) begin
      wdtcnt <= wdtcnt + 16'h0001;
    end
  end

endmodule

// File: rtl/omsp_watchdog.sv
// Watchdog / interval timer on the peripheral bus.
// Optional feature macro: WDT_INTERVAL_MODE_EN enables interval mode
// (writable TMSEL, wdtifg and wdt_irq). Without it every expiry resets.
//
// Bus access: a transfer happens in any cycle with per_en=1; per_we!=0
// makes it a write, otherwise it is a read. There is no wait state and
// no back-pressure; read data is valid combinationally in the same cycle.
module omsp_watchdog
  import omsp_watchdog_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0120,
  parameter int          DEC_WD    = 2,
  parameter int          WDTCTL    = 'h0
)(
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic        aclk_en,
  input  logic        smclk_en,
  input  logic        dbg_freeze,
  input  logic        wdtie,
  input  logic        wdtifg_clr,
  output logic [15:0] per_dout,
  output logic        wdtifg,
  output logic        wdt_irq,
  output logic        wdt_reset
);

  localparam int WDTCTL_W = WDTCTL / 2;

`ifdef WDT_INTERVAL_MODE_EN
  localparam logic [7:0] CTL_MASK = WDTCTL_MASK_FULL;
`else
  localparam logic [7:0] CTL_MASK = WDTCTL_MASK_NOINT;
`endif

  logic       reg_sel;
  logic       wdtctl_sel;
  logic       wdtctl_wacc;
  logic       pw_ok;
  logic       ctl_wr;
  logic       pw_viol;
  logic [7:0] wdtctl;
  logic       hold;
  logic       tmsel;
  logic       ssel;
  logic [1:0] wdtis;
  logic       tick;
  logic       cnt_clr;
  logic       expire;

  // Address decode and write qualification
  assign reg_sel     = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign wdtctl_sel  = reg_sel & (int'(per_addr[DEC_WD-2:0]) == WDTCTL_W);
  assign wdtctl_wacc = wdtctl_sel & (|per_we);
  assign pw_ok       = (per_we == 2'b11) & (per_din[15:8] == WDT_PASSWORD);
  assign ctl_wr      = wdtctl_wacc & pw_ok;
  assign pw_viol     = wdtctl_wacc & ~pw_ok;

  // Control register: only password-valid word writes update it
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      wdtctl <= 8'h00;
    end else if (ctl_wr) begin
      wdtctl <= per_din[7:0] & CTL_MASK;
    end
  end

  assign hold    = wdtctl[WDTHOLD];
  assign tmsel   = wdtctl[WDTTMSEL];
  assign ssel    = wdtctl[WDTSSEL];
  assign wdtis   = wdtctl[WDTIS0+1:WDTIS0];
  assign tick    = (ssel ? aclk_en : smclk_en) & ~hold & ~dbg_freeze;
  assign cnt_clr = ctl_wr & per_din[WDTCNTCL];

  omsp_wdt_counter u_counter (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .tick    (tick),
    .cnt_clr (cnt_clr),
    .wdtis   (wdtis),
    .expire  (expire)
  );

  // Registered reset request; violation and expiry merge into one pulse
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      wdt_reset <= 1'b0;
    end else begin
      wdt_reset <= (expire & ~tmsel) | pw_viol;
    end
  end

`ifdef WDT_INTERVAL_MODE_EN
  // Interval flag: a new expiry wins over a simultaneous acknowledge
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      wdtifg <= 1'b0;
    end else if (expire & tmsel) begin
      wdtifg <= 1'b1;
    end else if (wdtifg_clr) begin
      wdtifg <= 1'b0;
    end
  end

  assign wdt_irq = wdtifg & wdtie & tmsel;
`else
  logic unused_int_inputs;
  assign unused_int_inputs = wdtie ^ wdtifg_clr;
  assign wdtifg  = 1'b0;
  assign wdt_irq = 1'b0;
`endif

  // Read mux; CNTCL is never stored so it reads back as 0
  assign per_dout = wdtctl_sel ? {WDT_SIGNATURE, wdtctl} : 16'h0000;

endmodule

// File: tb/tb_omsp_watchdog.sv
// Self-checking bench for omsp_watchdog: directed scenarios plus a random
// phase, all checked against a cycle-level behavioural model.
module tb_omsp_watchdog;

  // ---------------- clock / reset ----------------
  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic        aclk_en;
  logic        smclk_en;
  logic        dbg_freeze;
  logic        wdtie;
  logic        wdtifg_clr;
  logic [15:0] per_dout;
  logic        wdtifg;
  logic        wdt_irq;
  logic        wdt_reset;

  always #5 mclk = ~mclk;

  omsp_watchdog dut (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .per_addr   (per_addr),
    .per_din    (per_din),
    .per_en     (per_en),
    .per_we     (per_we),
    .aclk_en    (aclk_en),
    .smclk_en   (smclk_en),
    .dbg_freeze (dbg_freeze),
    .wdtie      (wdtie),
    .wdtifg_clr (wdtifg_clr),
    .per_dout   (per_dout),
    .wdtifg     (wdtifg),
    .wdt_irq    (wdt_irq),
    .wdt_reset  (wdt_reset)
  );

`ifdef WDT_INTERVAL_MODE_EN
  localparam bit INTV = 1'b1;
`else
  localparam bit INTV = 1'b0;
`endif

  localparam logic [13:0] WDT_WADDR = 14'h0090;  // byte address 0x0120

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_hold, m_tmsel, m_ssel, m_ifg, m_rst;
  logic [1:0] m_is;
  int         m_cnt;
  int         rst_pulses = 0;
  logic [15:0] obs_dout;
  logic        obs_rst, obs_ifg, obs_irq;

  function automatic int period(input logic [1:0] is);
    case (is)
      2'b00:   return 32768;
      2'b01:   return 8192;
      2'b10:   return 512;
      default: return 64;
    endcase
  endfunction

  task automatic model_reset();
    m_hold = 0; m_tmsel = 0; m_ssel = 0; m_is = 2'b00;
    m_cnt = 0; m_ifg = 0; m_rst = 0;
  endtask

  // One mclk cycle: inputs already driven at the negedge. Checks read data
  // before the edge, registered outputs after it, and plays the clock
  // module by turning a reset request into a puc_rst pulse.
  task automatic step();
    bit sel, wr, valid, viol, tick, clr, expd, n_rst, n_ifg;
    int n_cnt;
    logic [15:0] e_dout;
    #1;
    sel    = per_en && (per_addr == WDT_WADDR);
    e_dout = sel ? {8'h69, m_hold, 2'b00, m_tmsel, 1'b0, m_ssel, m_is} : 16'h0000;
    obs_dout = per_dout;
    check("per_dout", per_dout, e_dout);
    wr    = sel && (per_we != 2'b00);
    valid = wr && (per_we == 2'b11) && (per_din[15:8] == 8'h5A);
    viol  = wr && !valid;
    tick  = (m_ssel ? aclk_en : smclk_en) && !m_hold && !dbg_freeze;
    clr   = valid && per_din[3];
    expd  = tick && !clr && (((m_cnt + 1) % period(m_is)) == 0);
    n_cnt = (clr || expd) ? 0 : (tick ? (m_cnt + 1) % 65536 : m_cnt);
    n_rst = (expd && !m_tmsel) || viol;
    n_ifg = INTV && ((expd && m_tmsel) || (m_ifg && !wdtifg_clr));
    if (valid) begin
      m_hold  = per_din[7];
      m_tmsel = INTV && per_din[4];
      m_ssel  = per_din[2];
      m_is    = per_din[1:0];
    end
    @(posedge mclk);
    #1;
    m_cnt = n_cnt; m_rst = n_rst; m_ifg = n_ifg;
    obs_rst = wdt_reset; obs_ifg = wdtifg; obs_irq = wdt_irq;
    if (wdt_reset) rst_pulses++;
    check("wdt_reset", wdt_reset, m_rst);
    check("wdtifg", wdtifg, m_ifg);
    check("wdt_irq", wdt_irq, m_ifg && wdtie && m_tmsel);
    if (m_rst || wdt_reset) begin
      puc_rst = 1'b1;
      model_reset();
    end
    @(negedge mclk);
    puc_rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    per_en = 0; per_we = 2'b00; per_addr = 14'h0000; per_din = 16'h0000;
    aclk_en = 0; smclk_en = 0; wdtifg_clr = 0;
  endtask

  task automatic bus_write(input logic [15:0] d, input logic [1:0] we);
    per_en = 1; per_addr = WDT_WADDR; per_we = we; per_din = d;
    step();
    idle();
  endtask

  task automatic bus_read();
    per_en = 1; per_addr = WDT_WADDR; per_we = 2'b00;
    step();
    idle();
  endtask

  task automatic ticks(input int n, input bit use_aclk);
    for (int i = 0; i < n; i++) begin
      aclk_en = use_aclk; smclk_en = !use_aclk;
      step();
    end
    aclk_en = 0; smclk_en = 0;
  endtask

  task automatic puc();
    puc_rst = 1'b1;
    model_reset();
    @(negedge mclk);
    puc_rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    idle();
    dbg_freeze = 0; wdtie = 0; puc_rst = 1'b1;
    model_reset();
    repeat (2) @(negedge mclk);
    puc_rst = 1'b0;
    #1;
    check("reset_wdt_reset", wdt_reset, 1'b0);
    check("reset_wdtifg", wdtifg, 1'b0);
    check("reset_wdt_irq", wdt_irq, 1'b0);
    @(negedge mclk);
    bus_read();
    check("reset_dout", obs_dout, 16'h6900);

    // 1: default watchdog expires on the 32768th SMCLK tick
    ticks(32767, 1'b0);
    check("t1_before_expiry", obs_rst, 1'b0);
    ticks(1, 1'b0);
    check("t1_expiry", obs_rst, 1'b1);

    // 2: HOLD freezes the counter
    puc();
    bus_write(16'h5A80, 2'b11);
    bus_read();
    check("t2_readback", obs_dout, 16'h6980);
    base = rst_pulses;
    bus_write(16'h5A83, 2'b11);
    ticks(3000, 1'b0);
    ticks(500, 1'b1);
    check("t2_no_reset", rst_pulses - base, 0);

    // 3: interval mode with /64
    puc();
    wdtie = 1;
    bus_write(16'h5A13, 2'b11);
    ticks(63, 1'b0);
`ifdef WDT_INTERVAL_MODE_EN
    check("t3_before", obs_ifg, 1'b0);
    ticks(1, 1'b0);
    check("t3_ifg", obs_ifg, 1'b1);
    check("t3_irq", obs_irq, 1'b1);
    check("t3_no_reset", obs_rst, 1'b0);
    wdtifg_clr = 1; step(); wdtifg_clr = 0;
    check("t3_ifg_clr", obs_ifg, 1'b0);
    check("t3_irq_clr", obs_irq, 1'b0);
    ticks(63, 1'b0);
    smclk_en = 1; wdtifg_clr = 1; step(); idle();
    check("t3_set_wins", obs_ifg, 1'b1);
    wdtifg_clr = 1; step(); wdtifg_clr = 0;
`else
    ticks(1, 1'b0);
    check("t3_reset", obs_rst, 1'b1);
    check("t3_ifg_tied", obs_ifg, 1'b0);
`endif
    wdtie = 0;

    // 4: password violations
    puc();
    bus_write(16'h5A06, 2'b11);
    bus_write(16'h1234, 2'b11);
    check("t4_bad_pw", obs_rst, 1'b1);
    bus_write(16'h5A00, 2'b01);
    check("t4_byte_wr", obs_rst, 1'b1);
    bus_read();
    check("t4_dout_after", obs_dout, 16'h6900);

    // 5: CNTCL write in the expiry tick cycle wins
    puc();
    bus_write(16'h5A02, 2'b11);
    ticks(511, 1'b0);
    check("t5_pre", obs_rst, 1'b0);
    smclk_en = 1;
    bus_write(16'h5A0A, 2'b11);
    check("t5_clear_wins", obs_rst, 1'b0);
    base = rst_pulses;
    ticks(511, 1'b0);
    check("t5_restart_quiet", rst_pulses - base, 0);
    ticks(1, 1'b0);
    check("t5_full_period", obs_rst, 1'b1);

    // 6: ACLK source with debug freeze
    puc();
    bus_write(16'h5A06, 2'b11);
    ticks(200, 1'b1);
    ticks(100, 1'b0);
    dbg_freeze = 1;
    ticks(50, 1'b1);
    dbg_freeze = 0;
    base = rst_pulses;
    ticks(311, 1'b1);
    check("t6_frozen_quiet", rst_pulses - base, 0);
    ticks(1, 1'b1);
    check("t6_expiry", obs_rst, 1'b1);

    // Random phase
    puc();
    bus_write(16'h5A03 | ($urandom_range(0, 1) ? 16'h0010 : 16'h0000), 2'b11);
    for (int i = 0; i < 4000; i++) begin
      smclk_en   = ($urandom_range(0, 1) == 0);
      aclk_en    = ($urandom_range(0, 3) == 0);
      dbg_freeze = ($urandom_range(0, 7) == 0);
      wdtie      = ($urandom_range(0, 1) == 0);
      wdtifg_clr = ($urandom_range(0, 7) == 0);
      per_en = 0; per_we = 2'b00; per_addr = 14'h0000; per_din = 16'h0000;
      if ($urandom_range(0, 29) == 0) begin
        per_en = 1;
        case ($urandom_range(0, 3))
          0:       per_addr = 14'h0091;
          1:       per_addr = 14'h0050;
          default: per_addr = WDT_WADDR;
        endcase
        per_we = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        per_din[15:8] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h5A;
        per_din[7:0]  = 8'($urandom) & 8'h7F;
        if ($urandom_range(0, 5) == 0) per_din[7] = 1'b1;
        if ($urandom_range(0, 1) == 0) per_din[1:0] = 2'b11;
      end
      step();
    end
    idle();
    dbg_freeze = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
